comm_loader: RTL and testbench

// Hardware initiator for the on-board UART command protocol: sends ping/write/read command sequences and checks every response.

---
 rtl/comm_loader.sv | 215 +++++++++++++++++++++
 tb/tb_comm_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// comm_loader: lock-step initiator for the UART ping/write/read protocol
// Rev 1.0
// ------------------------------------------------------------------
module comm_loader #(
  parameter int         WORDS          = 32,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] POLL_BYTE      = 8'h2E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [4:0]  img_addr,
  input  logic [15:0] img_data,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [15:0] rd_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IW = $clog2(2 * WORDS + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(2 * WORDS + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_PING  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   word_q, word_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     hold_q, hold_d;
  logic [7:0]      rhigh_q, rhigh_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_q, err_d;
  logic            rd_we_q, rd_we_d;
  logic [WW-1:0]   rd_addr_q, rd_addr_d;
  logic [15:0]     rd_wdata_q, rd_wdata_d;

  logic [7:0]      tx_byte;
  logic [7:0]      exp_byte;
  logic            any_ok;
  logic            is_last;
  logic            start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      idx_q      <= '0;
      word_q     <= '0;
      timer_q    <= '0;
      hold_q     <= 16'd0;
      rhigh_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= 2'd0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      rhigh_q    <= rhigh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_q      <= err_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    word_d     = word_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    rhigh_d    = rhigh_q;
    done_d     = done_q;
    error_d    = error_q;
    err_d      = err_q;
    rd_we_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    // busy trails the state by one cycle so it overlaps the done/error edge
    busy_d     = (state_q != S_IDLE);
    start_ok   = start && (state_q == S_IDLE) && !busy_q;

    is_last  = (op_q == OP_WRITE || op_q == OP_READ) ? (idx_q == LAST_IDX) : (idx_q == '0);
    tx_byte  = POLL_BYTE;
    exp_byte = 8'h00;
    any_ok   = 1'b0;
    if (idx_q == '0) begin
      case (op_q)
        OP_PING:  begin tx_byte = 8'h70; exp_byte = 8'h50; end
        OP_WRITE: begin tx_byte = 8'h77; exp_byte = 8'h57; end
        OP_READ:  begin tx_byte = 8'h72; exp_byte = 8'h52; end
        default:  begin tx_byte = 8'h78; exp_byte = 8'h3F; end
      endcase
    end else if (idx_q == LAST_IDX) begin
      exp_byte = 8'h45;
    end else if (op_q == OP_WRITE) begin
      tx_byte  = idx_q[0] ? hold_q[15:8] : hold_q[7:0];
      exp_byte = idx_q[0] ? 8'h2B : 8'h2D;
    end else begin
      any_ok = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d    = op;
          idx_d   = '0;
          word_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      // one cycle for img_data to follow the new img_addr before capture
      S_LOAD: begin
        hold_d  = img_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      default: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          if (any_ok || rx_data == exp_byte) begin
            if (any_ok) begin
              if (idx_q[0]) begin
                rhigh_d = rx_data;
              end else begin
                rd_we_d    = 1'b1;
                rd_addr_d  = word_q;
                rd_wdata_d = {rhigh_q, rx_data};
              end
            end
            if (is_last) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q + 1'b1;
              // a low byte closes a word; saturate so the count never wraps
              if (!idx_q[0] && idx_q != '0 && word_q != LAST_WORD)
                word_d = word_q + 1'b1;
              state_d = (op_q == OP_WRITE && idx_d[0] && idx_d != LAST_IDX) ? S_LOAD : S_SEND;
            end
          end else begin
            error_d = 1'b1;
            err_d   = 2'd2;
            state_d = S_IDLE;
          end
        end else if (timer_q == TMO_LAST) begin
          error_d = 1'b1;
          err_d   = 2'd1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = (state_q == S_SEND) ? tx_byte : 8'h00;
  assign img_addr = 5'(word_q);
  assign rd_we    = rd_we_q;
  assign rd_addr  = 5'(rd_addr_q);
  assign rd_wdata = rd_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_q;

endmodule
`default_nettype wire

// File: tb/tb_comm_loader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_comm_loader: directed bench with a byte-level responder model
// Rev 1.0
// ------------------------------------------------------------------
module tb_comm_loader;

  localparam int LASTP = 65;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [4:0]  img_addr;
  logic [15:0] img_data;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [15:0] rd_wdata;
  logic        busy, done, error;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int mode   = 0;
  int bad_at = -1;
  bit mute   = 1'b0;
  int cyc    = 0;
  int hs_cyc = 0;
  int p      = 0;
  int pend   = 0;
  int txcnt  = 0;
  int rdcnt  = 0;
  logic [7:0]  rep = 8'h00;
  logic [7:0]  txlog [0:79];
  logic [4:0]  rda   [0:39];
  logic [15:0] rdd   [0:39];

  comm_loader #(.WORDS(32), .TIMEOUT_CYCLES(50), .POLL_BYTE(8'h2E)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .img_addr(img_addr), .img_data(img_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always_comb img_data = 16'hA500 + {11'd0, img_addr};

  function automatic logic [7:0] reply(input int m, input int pos);
    logic [15:0] w;
    w = 16'h1234 + 16'((pos - 1) / 2);
    case (m)
      0: return 8'h50;
      3: return 8'h3F;
      1: begin
        if (pos == 0) return 8'h57;
        else if (pos == LASTP) return 8'h45;
        else if (pos % 2 == 1) return 8'h2B;
        else return 8'h2D;
      end
      default: begin
        if (pos == 0) return 8'h52;
        else if (pos == LASTP) return 8'h45;
        else if (pos % 2 == 1) return w[15:8];
        else return w[7:0];
      end
    endcase
  endfunction

  // responder: logs tx bytes and rd_we writes, answers each byte 3 cycles later
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rx_valid = 1'b0;
      if (start && !busy) begin
        p = 0; txcnt = 0; rdcnt = 0; pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rx_valid = 1'b1;
          rx_data  = rep;
        end
      end
      if (rd_we && rdcnt < 40) begin
        rda[rdcnt] = rd_addr;
        rdd[rdcnt] = rd_wdata;
        rdcnt++;
      end
      tx_ready = (cyc % 3) != 0;
      if (tx_valid && tx_ready) begin
        if (txcnt < 80) txlog[txcnt] = tx_data;
        txcnt++;
        hs_cyc = cyc;
        rep = (p == bad_at) ? 8'h3F : reply(mode, p);
        if (!mute) pend = 3;
        p++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] o);
    @(posedge clk); #1;
    start = 1'b1; op = o;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #2;
      if (done || error) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    logic [7:0] eb;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    chk("rst_error",    {31'd0, error}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_img_addr", {27'd0, img_addr}, 32'd0);
    chk("rst_rd_addr",  {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_wdata", {16'd0, rd_wdata}, 32'd0);
    chk("rst_rd_we",    {31'd0, rd_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ping
    mode = 0;
    do_start(2'd0);
    wait_end(200, "ping");
    chk("ping_done",      {31'd0, done}, 32'd1);
    chk("ping_error",     {31'd0, error}, 32'd0);
    chk("ping_busy_hold", {31'd0, busy}, 32'd1);
    chk("ping_txcnt",     txcnt, 32'd1);
    chk("ping_byte",      {24'd0, txlog[0]}, 32'h70);
    @(posedge clk); #2;
    chk("ping_busy_fall", {31'd0, busy}, 32'd0);

    // write image, with a stray start pulse mid-transfer
    mode = 1;
    do_start(2'd1);
    repeat (20) @(posedge clk);
    #1; start = 1'b1; op = 2'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_end(3000, "write");
    chk("wr_done",     {31'd0, done}, 32'd1);
    chk("wr_err_code", {30'd0, err_code}, 32'd0);
    chk("wr_txcnt",    txcnt, 32'd66);
    for (int k = 0; k < 66; k++) begin
      if (k == 0) eb = 8'h77;
      else if (k == LASTP) eb = 8'h2E;
      else if (k % 2 == 1) eb = 8'hA5;
      else eb = 8'((k - 2) / 2);
      chk($sformatf("wr_byte%0d", k), {24'd0, txlog[k]}, {24'd0, eb});
    end

    // read back
    mode = 2;
    do_start(2'd2);
    wait_end(3000, "read");
    chk("rd_done",  {31'd0, done}, 32'd1);
    chk("rd_error", {31'd0, error}, 32'd0);
    chk("rd_txcnt", txcnt, 32'd66);
    chk("rd_first", {24'd0, txlog[0]}, 32'h72);
    chk("rd_final", {24'd0, txlog[65]}, 32'h2E);
    chk("rd_count", rdcnt, 32'd32);
    for (int n = 0; n < 32; n++) begin
      chk($sformatf("rd_addr%0d", n), {27'd0, rda[n]}, n);
      chk($sformatf("rd_data%0d", n), {16'd0, rdd[n]}, 32'h1234 + n);
    end

    // bad reply to the third byte
    mode = 1; bad_at = 2;
    do_start(2'd1);
    wait_end(500, "bad");
    chk("bad_error",    {31'd0, error}, 32'd1);
    chk("bad_err_code", {30'd0, err_code}, 32'd2);
    chk("bad_done",     {31'd0, done}, 32'd0);
    repeat (20) @(posedge clk);
    #2;
    chk("bad_txcnt", txcnt, 32'd3);
    bad_at = -1;

    // timeout: no reply at all
    mode = 0; mute = 1'b1;
    do_start(2'd0);
    wait_end(300, "tmo");
    chk("tmo_error",    {31'd0, error}, 32'd1);
    chk("tmo_err_code", {30'd0, err_code}, 32'd1);
    chk("tmo_cycles",   cyc - hs_cyc, 32'd50);
    chk("tmo_txcnt",    txcnt, 32'd1);
    mute = 1'b0;

    // reserved opcode
    mode = 3;
    do_start(2'd3);
    wait_end(200, "rsv");
    chk("rsv_done", {31'd0, done}, 32'd1);
    chk("rsv_byte", {24'd0, txlog[0]}, 32'h78);

    // reset in the middle of a read
    mode = 2;
    do_start(2'd2);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(posedge clk); #2;
        if (rdcnt >= 10) begin got = 1'b1; break; end
      end
      if (!got) chk("mid_reach10", 32'd0, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_busy",     {31'd0, busy}, 32'd0);
    chk("mid_done",     {31'd0, done}, 32'd0);
    chk("mid_error",    {31'd0, error}, 32'd0);
    chk("mid_rd_we",    {31'd0, rd_we}, 32'd0);
    rst = 1'b0;
    cnt = rdcnt;
    repeat (40) @(posedge clk);
    #2;
    chk("mid_no_more_we", rdcnt, cnt);
    mode = 0;
    do_start(2'd0);
    wait_end(200, "mid_ping");
    chk("mid_ping_done",  {31'd0, done}, 32'd1);
    chk("mid_ping_error", {31'd0, error}, 32'd0);
    chk("mid_ping_byte",  {24'd0, txlog[0]}, 32'h70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
